// File: rtl/vga_sync_decoder.sv
// VGA sink: recovers pixel coordinates and colour from an hs/vs/rgb stream,
// measures every line and frame against the nominal timing and reports lock.
module vga_sync_decoder #(
   parameter int   H_ACTIVE = 1024,
   parameter int   H_FP     = 24,
   parameter int   H_SYNC   = 136,
   parameter int   H_BP     = 160,
   parameter int   V_ACTIVE = 768,
   parameter int   V_FP     = 3,
   parameter int   V_SYNC   = 6,
   parameter int   V_BP     = 29,
   parameter logic SYNC_ACT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hs,
   input  logic        vs,
   input  logic [3:0]  r,
   input  logic [3:0]  g,
   input  logic [3:0]  b,
   output logic [10:0] pix_x,
   output logic [9:0]  pix_y,
   output logic [11:0] pix_rgb,
   output logic        pix_valid,
   output logic        frame_start,
   output logic        locked,
   output logic        h_err,
   output logic        v_err,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
   localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_FULL  = 10'(V_TOTAL);
   localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
   localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_ACQUIRE,
      ST_LOCKED
   } state_t;

   function automatic logic [10:0] sat_inc_h(input logic [10:0] cnt);
      sat_inc_h = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
   endfunction

   function automatic logic [9:0] sat_inc_v(input logic [9:0] cnt);
      sat_inc_v = (cnt == 10'h3FF) ? cnt : cnt + 10'd1;
   endfunction

   logic        r_hs_p0;
   logic        r_hs_p1;
   logic        r_vs_p0;
   logic        r_vs_p1;
   logic [11:0] r_rgb_p0;

   logic [10:0] r_h_cnt;
   logic [9:0]  r_v_cnt;
   logic        r_vs_pend;
   state_t      r_state;
   logic        r_acq_bad;

   logic        w_hs_edge;
   logic        w_vs_edge;
   logic        w_searching;
   logic [10:0] w_h_nxt;
   logic [9:0]  w_v_nxt;
   logic        w_vs_pend_nxt;
   logic        w_bnd;
   logic        w_h_err;
   logic        w_v_err;
   logic        w_err;
   logic        w_active;

   // ---- stage p0: input capture and edge-detect delay ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hs_p0  <= 1'b0;
         r_hs_p1  <= 1'b0;
         r_vs_p0  <= 1'b0;
         r_vs_p1  <= 1'b0;
         r_rgb_p0 <= '0;
      end else begin
         r_hs_p0  <= hs;
         r_hs_p1  <= r_hs_p0;
         r_vs_p0  <= vs;
         r_vs_p1  <= r_vs_p0;
         r_rgb_p0 <= {r, g, b};
      end
   end

   assign w_hs_edge   = (r_hs_p0 == SYNC_ACT) && (r_hs_p1 != SYNC_ACT);
   assign w_vs_edge   = (r_vs_p0 == SYNC_ACT) && (r_vs_p1 != SYNC_ACT);
   assign w_searching = (r_state == ST_SEARCH);

   // A vs edge is held pending until the next hs edge so that the frame
   // boundary always lands on a line start, whatever the vs phase.
   always_comb begin
      w_h_nxt       = sat_inc_h(r_h_cnt);
      w_v_nxt       = r_v_cnt;
      w_vs_pend_nxt = r_vs_pend | w_vs_edge;
      w_bnd         = 1'b0;
      w_h_err       = 1'b0;
      w_v_err       = 1'b0;
      if (w_hs_edge) begin
         w_h_nxt = '0;
         w_h_err = !w_searching && (r_h_cnt != H_LAST);
         if (r_vs_pend || w_vs_edge) begin
            w_v_nxt       = '0;
            w_vs_pend_nxt = 1'b0;
            w_bnd         = 1'b1;
            w_v_err       = !w_searching && (r_v_cnt != V_LAST);
         end else begin
            w_v_nxt = sat_inc_v(r_v_cnt);
            w_v_err = !w_searching && (w_v_nxt == V_FULL);
         end
      end
   end

   assign w_err    = w_h_err | w_v_err;
   assign w_active = (w_h_nxt >= H_START) && (w_h_nxt < H_END) &&
                     (w_v_nxt >= V_START) && (w_v_nxt < V_END);

   // ---- stage p1: counters and pixel outputs ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_cnt   <= '0;
         r_v_cnt   <= '0;
         r_vs_pend <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_rgb   <= '0;
      end else begin
         r_h_cnt   <= w_h_nxt;
         r_v_cnt   <= w_v_nxt;
         r_vs_pend <= w_vs_pend_nxt;
         pix_x     <= w_h_nxt - H_START;
         pix_y     <= w_v_nxt - V_START;
         pix_rgb   <= r_rgb_p0;
      end
   end

   // Lock FSM; pix_valid follows the post-transition state so an error
   // blanks the pixel on the very edge that reports it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_SEARCH;
         r_acq_bad   <= 1'b0;
         locked      <= 1'b0;
         pix_valid   <= 1'b0;
         frame_start <= 1'b0;
         h_err       <= 1'b0;
         v_err       <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         frame_start <= w_bnd && !w_searching;
         h_err       <= w_h_err;
         v_err       <= w_v_err;
         pix_valid   <= 1'b0;
         case (r_state)
            ST_SEARCH: begin
               if (w_bnd) begin
                  r_state   <= ST_ACQUIRE;
                  r_acq_bad <= 1'b0;
               end
            end
            ST_ACQUIRE: begin
               if (w_bnd) begin
                  if (r_acq_bad || w_err) begin
                     r_acq_bad <= 1'b0;
                  end else begin
                     r_state   <= ST_LOCKED;
                     locked    <= 1'b1;
                     pix_valid <= w_active;
                     frame_cnt <= frame_cnt + 16'd1;
                  end
               end else if (w_err) begin
                  r_acq_bad <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (w_err) begin
                  r_state <= ST_SEARCH;
                  locked  <= 1'b0;
               end else begin
                  pix_valid <= w_active;
                  if (w_bnd) frame_cnt <= frame_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= ST_SEARCH;
               locked  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomized scoreboard bench for vga_sync_decoder using a reduced raster so
// many complete frames fit in a short run.
module tb_vga_sync_decoder;

   localparam int HA  = 16;
   localparam int HF  = 2;
   localparam int HSY = 3;
   localparam int HB  = 4;
   localparam int VA  = 8;
   localparam int VF  = 1;
   localparam int VSY = 2;
   localparam int VB  = 3;
   localparam int HT  = HA + HF + HSY + HB;
   localparam int VT  = VA + VF + VSY + VB;

   localparam int S_SEARCH  = 0;
   localparam int S_ACQUIRE = 1;
   localparam int S_LOCKED  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        hs;
   logic        vs;
   logic [3:0]  r;
   logic [3:0]  g;
   logic [3:0]  b;
   logic [10:0] pix_x;
   logic [9:0]  pix_y;
   logic [11:0] pix_rgb;
   logic        pix_valid;
   logic        frame_start;
   logic        locked;
   logic        h_err;
   logic        v_err;
   logic [15:0] frame_cnt;

   vga_sync_decoder #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .SYNC_ACT(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
      .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
      .frame_start(frame_start), .locked(locked), .h_err(h_err), .v_err(v_err),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int x;
      int y;
      int rgb;
      bit valid;
      bit fs;
      bit herr;
      bit verr;
      bit lck;
      int fcnt;
   } exp_t;

   exp_t q[$];
   int   n_checks    = 0;
   int   n_errors    = 0;
   int   rst_chk_cyc = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 20)
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: raster position, pending vs and lock state as integers.
   int m_h, m_v, m_st, m_fcnt;
   bit m_pend, m_bad, m_phs, m_pvs;

   task automatic m_reset();
      m_h = 0; m_v = 0; m_st = S_SEARCH; m_fcnt = 0;
      m_pend = 0; m_bad = 0; m_phs = 0; m_pvs = 0;
   endtask

   task automatic m_step(input bit ihs, input bit ivs, input logic [11:0] rgb, input int ocyc);
      bit   hse, vse, bnd, he, ve, err, act;
      int   ph, pv;
      exp_t e;
      hse = !ihs && m_phs;
      vse = !ivs && m_pvs;
      m_phs = ihs;
      m_pvs = ivs;
      bnd = 0; he = 0; ve = 0;
      ph = m_h; pv = m_v;
      if (hse) begin
         m_h = 0;
         if (m_pend || vse) begin
            m_v = 0; m_pend = 0; bnd = 1;
         end else begin
            m_v = (m_v < 1023) ? m_v + 1 : 1023;
         end
         if (m_st != S_SEARCH) begin
            he = (ph != HT - 1);
            ve = bnd ? (pv != VT - 1) : (m_v == VT);
         end
      end else begin
         m_h = (m_h < 2047) ? m_h + 1 : 2047;
         if (vse) m_pend = 1;
      end
      err  = he || ve;
      e.fs = bnd && (m_st != S_SEARCH);
      case (m_st)
         S_SEARCH:  if (bnd) begin m_st = S_ACQUIRE; m_bad = 0; end
         S_ACQUIRE: begin
            if (bnd) begin
               if (m_bad || err) m_bad = 0;
               else begin m_st = S_LOCKED; m_fcnt = (m_fcnt + 1) % 65536; end
            end else if (err) m_bad = 1;
         end
         default: begin
            if (err) m_st = S_SEARCH;
            else if (bnd) m_fcnt = (m_fcnt + 1) % 65536;
         end
      endcase
      act = (m_h >= HSY + HB) && (m_h < HSY + HB + HA) &&
            (m_v >= VSY + VB) && (m_v < VSY + VB + VA);
      e.cyc   = ocyc;
      e.x     = m_h - (HSY + HB);
      e.y     = m_v - (VSY + VB);
      e.rgb   = int'(rgb);
      e.valid = (m_st == S_LOCKED) && act;
      e.herr  = he;
      e.verr  = ve;
      e.lck   = (m_st == S_LOCKED);
      e.fcnt  = m_fcnt;
      if (e.valid || e.fs || e.herr || e.verr) q.push_back(e);
   endtask

   task automatic drive(input bit ihs, input bit ivs, input logic [11:0] rgb, input bit irst);
      @(posedge clk);
      #1;
      rst = irst; hs = ihs; vs = ivs; {r, g, b} = rgb;
      if (irst) begin
         while (q.size() > 0 && q[$].cyc >= cyc + 1) void'(q.pop_back());
         rst_chk_cyc = cyc + 1;
         m_reset();
         m_step(1'b0, 1'b0, 12'h000, cyc + 2);
      end else begin
         m_step(ihs, ivs, rgb, cyc + 2);
      end
   endtask

   // One frame starting with its vs lines; 'lead' pulls the next frame's vs
   // edge that many clocks ahead into this frame's last line.
   task automatic send_frame(input int short_line, input int delta, input bit no_vs,
                             input int lead, input bit rnd, input int rst_at);
      int          gidx, len, x, y;
      bit          ihs, ivs;
      logic [11:0] px;
      gidx = 0;
      for (int l = 0; l < VT; l++) begin
         len = (l == short_line) ? HT + delta : HT;
         for (int p = 0; p < len; p++) begin
            ihs = (p >= HSY);
            ivs = 1'b1;
            if (!no_vs && l < VSY) ivs = 1'b0;
            if (l == VT - 1 && lead > 0 && p >= len - lead) ivs = 1'b0;
            x = p - (HSY + HB);
            y = l - (VSY + VB);
            if (rnd) px = 12'($urandom);
            else if (x >= 0 && x < HA && y >= 0 && y < VA) px = {4'(x), 4'(y), 4'h5};
            else px = 12'h000;
            drive(ihs, ivs, px, gidx == rst_at);
            gidx++;
         end
      end
   endtask

   exp_t me;
   always @(negedge clk) begin
      if (cyc == rst_chk_cyc) begin
         chk("rst_pix_valid", pix_valid, 0);
         chk("rst_frame_start", frame_start, 0);
         chk("rst_locked", locked, 0);
         chk("rst_errs", {h_err, v_err}, 0);
         chk("rst_frame_cnt", frame_cnt, 0);
         chk("rst_pix_data", {pix_x, pix_y, pix_rgb}, 0);
      end
      if (pix_valid || frame_start || h_err || v_err) begin
         if (q.size() == 0) begin
            chk("event_queue_size", q.size(), 1);
         end else begin
            me = q.pop_front();
            chk("event_cycle", cyc, me.cyc);
            chk("pix_valid", pix_valid, me.valid);
            chk("frame_start", frame_start, me.fs);
            chk("h_err", h_err, me.herr);
            chk("v_err", v_err, me.verr);
            chk("locked", locked, me.lck);
            chk("frame_cnt", frame_cnt, me.fcnt);
            if (me.valid) begin
               chk("pix_x", pix_x, me.x);
               chk("pix_y", pix_y, me.y);
               chk("pix_rgb", pix_rgb, me.rgb);
            end
         end
      end
   end

   bit nv[17];
   int sl, dl, ld;

   initial begin
      rst = 1'b1; hs = 1'b1; vs = 1'b1; r = '0; g = '0; b = '0;
      m_reset();
      repeat (4) drive(1'b1, 1'b1, 12'h000, 1'b1);
      chk("reset_locked", locked, 0);
      chk("reset_frame_cnt", frame_cnt, 0);
      chk("reset_pix_valid", pix_valid, 0);
      repeat (5) drive(1'b1, 1'b1, 12'h000, 1'b0);

      // clean pattern frames: lock at the second boundary
      send_frame(-1, 0, 0, 0, 0, -1);
      chk("acquire_not_locked", locked, 0);
      send_frame(-1, 0, 0, 0, 0, -1);
      send_frame(-1, 0, 0, 0, 0, -1);
      chk("locked_after_3", locked, 1);
      chk("fcnt_after_3", frame_cnt, 2);

      // one line one clock short while locked
      send_frame(5, -1, 0, 0, 0, -1);
      chk("short_line_unlock", locked, 0);
      chk("short_line_fcnt_kept", frame_cnt, 3);
      send_frame(-1, 0, 0, 0, 0, -1);
      chk("short_line_acquire", locked, 0);
      send_frame(-1, 0, 0, 0, 0, -1);
      chk("short_line_relock", locked, 1);
      chk("short_line_relock_fcnt", frame_cnt, 4);

      // missing vs
      send_frame(-1, 0, 1, 0, 0, -1);
      chk("missing_vs_unlock", locked, 0);
      chk("missing_vs_fcnt", frame_cnt, 4);
      send_frame(-1, 0, 0, 0, 0, -1);
      send_frame(-1, 0, 0, 0, 0, -1);
      chk("missing_vs_relock", locked, 1);
      chk("missing_vs_fcnt_relock", frame_cnt, 5);

      // vs edge ahead of the hs edge
      send_frame(-1, 0, 0, $urandom_range(1, HT - 2), 1, -1);
      send_frame(-1, 0, 0, 0, 1, -1);
      chk("vs_lead_locked", locked, 1);
      chk("vs_lead_fcnt", frame_cnt, 7);

      // randomized stream with occasional line-length faults and lost vs
      for (int i = 0; i < 16; i++) nv[i] = ($urandom_range(0, 6) == 0);
      nv[16] = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, VT - 1)) : -1;
         dl = ($urandom_range(0, 1) == 0) ? -1 : 1;
         ld = (nv[i+1] || $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, HT - 2));
         send_frame(sl, dl, nv[i], ld, 1, -1);
      end
      repeat (3) send_frame(-1, 0, 0, 0, 1, -1);
      chk("random_relock", locked, 1);

      // reset mid-frame while locked
      send_frame(-1, 0, 0, 0, 1, $urandom_range((VSY + VB) * HT, (VT - 2) * HT));
      chk("post_reset_unlocked", locked, 0);
      send_frame(-1, 0, 0, 0, 0, -1);
      chk("post_reset_acquire", locked, 0);
      send_frame(-1, 0, 0, 0, 0, -1);
      chk("post_reset_locked", locked, 1);
      chk("post_reset_fcnt", frame_cnt, 1);

      repeat (4) drive(1'b1, 1'b1, 12'h000, 1'b0);
      chk("scoreboard_leftover", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
